// File: rtl/fifo_stream_pkg.sv
// Shared types and constants for the FIFO read-side drain stage.
package fifo_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } drain_state_e;

  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_FRAME_LEN  = 4;
  localparam int FRAMES_W       = 16;

endpackage

// File: rtl/stream_buf2.sv
// Two-entry output buffer absorbing the FIFO's registered read latency.
module stream_buf2 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic [1:0]   occ
);

  logic [W-1:0] slot0_q, slot0_d;
  logic [W-1:0] slot1_q, slot1_d;
  logic [1:0]   occ_q, occ_d;

  // slot0 is always the head; a pop shifts slot1 forward.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    occ_d   = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) slot0_d = push_data;
        else               slot1_d = push_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        occ_d   = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          slot0_d = push_data;
        end else begin
          slot0_d = slot1_q;
          slot1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      occ_q   <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      occ_q   <= occ_d;
    end
  end

  assign head_data = slot0_q;
  assign occ       = occ_q;

endmodule

// File: rtl/fifo_stream_drain.sv
// Drains a synchronous FIFO into a framed valid/ready stream without ever
// over-reading it; flags any FIFO underflow as a sticky error.
module fifo_stream_drain
  import fifo_stream_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int FRAME_LEN  = DEF_FRAME_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic                  fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  underflow_err,
  output logic [FRAMES_W-1:0]   frames_done
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  drain_state_e        state_q, state_d;
  logic [IDX_W-1:0]    issue_idx_q, issue_idx_d;
  logic [IDX_W-1:0]    out_idx_q, out_idx_d;
  logic                inflight_q, inflight_d;
  logic                uf_err_q, uf_err_d;
  logic [FRAMES_W-1:0] frames_q, frames_d;
  logic [1:0]          occ;
  logic                pop, push, issue_ok, rd_en;

  function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
  endfunction

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid && m_ready;
  assign push    = inflight_q && !fifo_underflow;

  // A same-cycle pop frees a slot, so m_ready feeds the read strobe directly.
  always_comb begin
    issue_ok = (state_q == RUN) || ((state_q == DRAIN) && (issue_idx_q != '0));
    rd_en    = issue_ok && !fifo_empty &&
               (({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
  end

  always_comb begin
    state_d     = state_q;
    issue_idx_d = issue_idx_q;
    out_idx_d   = out_idx_q;
    inflight_d  = rd_en;
    uf_err_d    = uf_err_q || fifo_underflow;
    frames_d    = frames_q;
    case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = DRAIN;
      DRAIN:   if ((issue_idx_q == '0) && (occ == 2'd0) && !inflight_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rd_en) issue_idx_d = idx_next(issue_idx_q);
    if (pop) begin
      out_idx_d = idx_next(out_idx_q);
      if (m_last) frames_d = frames_q + FRAMES_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      issue_idx_q <= '0;
      out_idx_q   <= '0;
      inflight_q  <= 1'b0;
      uf_err_q    <= 1'b0;
      frames_q    <= '0;
    end else begin
      state_q     <= state_d;
      issue_idx_q <= issue_idx_d;
      out_idx_q   <= out_idx_d;
      inflight_q  <= inflight_d;
      uf_err_q    <= uf_err_d;
      frames_q    <= frames_d;
    end
  end

  stream_buf2 #(
    .W(FIFO_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (fifo_data_out),
    .pop       (pop),
    .head_data (m_data),
    .occ       (occ)
  );

  assign fifo_rd_en    = rd_en;
  assign m_last        = m_valid && (out_idx_q == LAST_IDX);
  assign busy          = (state_q != IDLE) || (occ != 2'd0) || inflight_q;
  assign underflow_err = uf_err_q;
  assign frames_done   = frames_q;

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain: behavioural FIFO plus an in-order scoreboard.
module tb_fifo_stream_drain;

  localparam int FW    = 16;
  localparam int FL    = 4;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst_n, en, m_ready;
  logic          fifo_rd_en, fifo_empty, fifo_underflow;
  logic          m_valid, m_last, busy, underflow_err;
  logic [FW-1:0] fifo_data_out = '0;
  logic [FW-1:0] m_data;
  logic [15:0]   frames_done;

  logic [FW-1:0] mem     [DEPTH];
  logic [FW-1:0] rec_mem [DEPTH];
  int wr_ptr = 0, rd_ptr = 0, rec_wr = 0, rec_rd = 0;
  int reads_total = 0, pops_total = 0, out_cnt = 0, frames_exp = 0;
  logic tb_uf = 1'b0, force_uf = 1'b0;
  logic prev_stall = 1'b0, prev_last = 1'b0;
  logic [FW-1:0] prev_data = '0;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  assign fifo_empty     = (rd_ptr == wr_ptr);
  assign fifo_underflow = tb_uf | force_uf;

  fifo_stream_drain #(.FIFO_WIDTH(FW), .FRAME_LEN(FL)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .fifo_rd_en     (fifo_rd_en),
    .fifo_data_out  (fifo_data_out),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_last         (m_last),
    .busy           (busy),
    .underflow_err  (underflow_err),
    .frames_done    (frames_done)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural FIFO with registered read data and underflow flag.
  always @(posedge clk) begin
    if (!rst_n) begin
      reads_total <= 0;
      rec_wr      <= 0;
      tb_uf       <= 1'b0;
    end else begin
      tb_uf <= 1'b0;
      if (fifo_rd_en) begin
        if (rd_ptr != wr_ptr) begin
          fifo_data_out           <= mem[rd_ptr % DEPTH];
          rec_mem[rec_wr % DEPTH] <= mem[rd_ptr % DEPTH];
          rec_wr                  <= rec_wr + 1;
          rd_ptr                  <= rd_ptr + 1;
          reads_total             <= reads_total + 1;
        end else begin
          tb_uf <= 1'b1;
        end
      end
    end
  end

  // Stream scoreboard: words leave in read order, framed every FL words.
  always @(negedge clk) begin
    if (!rst_n) begin
      out_cnt    <= 0;
      frames_exp <= 0;
      pops_total <= 0;
      rec_rd     <= 0;
      prev_stall <= 1'b0;
    end else begin
      check_val("frames_done", 32'(frames_done), 32'(frames_exp[15:0]));
      check_val("no_empty_read", 32'(fifo_rd_en && fifo_empty), 32'd0);
      check_val("inflight_bound", 32'((reads_total - pops_total) <= 2), 32'd1);
      if (prev_stall) begin
        check_val("hold_valid", 32'(m_valid), 32'd1);
        check_val("hold_data", 32'(m_data), 32'(prev_data));
        check_val("hold_last", 32'(m_last), 32'(prev_last));
      end
      if (m_valid && m_ready) begin
        check_val("sb_word_avail", 32'(rec_rd < rec_wr), 32'd1);
        check_val("m_data", 32'(m_data), 32'(rec_mem[rec_rd % DEPTH]));
        check_val("m_last", 32'(m_last), 32'((out_cnt % FL) == FL - 1));
        rec_rd     <= rec_rd + 1;
        out_cnt    <= out_cnt + 1;
        pops_total <= pops_total + 1;
        if ((out_cnt % FL) == FL - 1) frames_exp <= frames_exp + 1;
      end else if (!m_valid) begin
        check_val("last_without_valid", 32'(m_last), 32'd0);
      end
      prev_stall <= m_valid && !m_ready;
      prev_data  <= m_data;
      prev_last  <= m_last;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_word(input logic [FW-1:0] w);
    mem[wr_ptr % DEPTH] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (!busy) break;
      tick(1);
    end
    check_val("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
    check_val({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check_val({tag, "_m_data"}, 32'(m_data), 32'd0);
    check_val({tag, "_m_last"}, 32'(m_last), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_uf_err"}, 32'(underflow_err), 32'd0);
    check_val({tag, "_frames"}, 32'(frames_done), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, p0, first_rd, last_rd, nrd, first_v;
    rst_n = 1'b0; en = 1'b0; m_ready = 1'b0;
    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(2);

    // Eight preloaded words, full throughput, two frames.
    for (int i = 1; i <= 8; i++) push_word(16'(i));
    en = 1'b1; m_ready = 1'b1;
    first_rd = -1; last_rd = -1; nrd = 0; first_v = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_rd_en) begin
        if (first_rd < 0) first_rd = i;
        last_rd = i;
        nrd++;
      end
      if (m_valid && first_v < 0) first_v = i;
    end
    check_val("frame_rd_count", 32'(nrd), 32'd8);
    check_val("frame_rd_consecutive", 32'(last_rd - first_rd), 32'd7);
    check_val("frame_latency", 32'(first_v - first_rd), 32'd2);
    tick(1);
    en = 1'b0;
    wait_idle(50);
    check_val("frame_frames_done", 32'(frames_done), 32'd2);

    // Backpressure: only two words may be pulled while stalled.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(16'(16'h0100 + i));
    r0 = reads_total;
    en = 1'b1;
    tick(10);
    check_val("bp_reads", 32'(reads_total - r0), 32'd2);
    check_val("bp_valid", 32'(m_valid), 32'd1);
    check_val("bp_head", 32'(m_data), 32'h0100);
    p0 = pops_total;
    m_ready = 1'b1;
    tick(10);
    check_val("bp_pops", 32'(pops_total - p0), 32'd4);
    en = 1'b0;
    wait_idle(50);

    // Drain completes the open frame and leaves the rest in the FIFO.
    for (int i = 0; i < 6; i++) push_word(16'(16'h0200 + i));
    r0 = reads_total;
    en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (reads_total - r0 >= 2) break;
    end
    en = 1'b0;
    wait_idle(50);
    check_val("drain_reads", 32'(reads_total - r0), 32'd4);
    check_val("drain_left", 32'(wr_ptr - rd_ptr), 32'd2);
    wr_ptr = rd_ptr;

    // Empty FIFO never read; forced underflow is sticky.
    r0 = reads_total;
    en = 1'b1;
    tick(10);
    check_val("empty_reads", 32'(reads_total - r0), 32'd0);
    check_val("empty_uf_err", 32'(underflow_err), 32'd0);
    force_uf = 1'b1;
    tick(1);
    force_uf = 1'b0;
    tick(1);
    check_val("uf_set", 32'(underflow_err), 32'd1);
    tick(5);
    check_val("uf_sticky", 32'(underflow_err), 32'd1);
    en = 1'b0;
    wait_idle(50);

    // Randomised traffic, enable toggling and backpressure.
    en = 1'b1;
    for (int i = 0; i < 800; i++) begin
      tick(1);
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0 && (wr_ptr - rd_ptr) < 600) push_word(16'($urandom));
      if ($urandom_range(0, 39) == 0) en = ~en;
    end
    en = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      if (wr_ptr == rd_ptr) push_word(16'($urandom));
      tick(1);
    end
    check_val("rand_idle", 32'(busy), 32'd0);
    check_val("rand_frame_aligned", 32'(reads_total % FL), 32'd0);
    check_val("rand_all_delivered", 32'(pops_total), 32'(reads_total));
    wr_ptr = rd_ptr;

    // Asynchronous reset with two words buffered.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(16'(16'h0300 + i));
    r0 = reads_total;
    en = 1'b1;
    tick(6);
    check_val("pre_reset_reads", 32'(reads_total - r0), 32'd2);
    check_val("pre_reset_valid", 32'(m_valid), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    en = 1'b0;
    wr_ptr = rd_ptr;
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) push_word(16'(16'h0400 + i));
    en = 1'b1; m_ready = 1'b1;
    tick(12);
    en = 1'b0;
    wait_idle(50);
    check_val("post_reset_frames", 32'(frames_done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
